j1a_bus_bridge: RTL

//  Downstream bus bridge for the J1A core's shared-strobe, lock-step instruction/data buses.
//  - Serves instruction fetches and RAM data accesses from one dual-port synchronous block RAM.
//  - Forwards data accesses at or above IO_BASE to a Wishbone I/O slave, with a wait-state timeout.
//  - Returns the single shared ACK the core needs to advance.

---
 rtl/j1a_bus_bridge_pkg.sv | 22 ++
 rtl/j1a_bus_bridge_timer.sv | 38 +++
 rtl/j1a_bus_bridge.sv | 132 +++++++++++++
 3 files changed

// File: rtl/j1a_bus_bridge_pkg.sv
// Shared definitions for the J1A bus bridge: FSM encoding, error read value
// and default memory map / timeout settings.
package j1a_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAM_ACK = 2'd1,
        ST_IO_WAIT = 2'd2,
        ST_IO_ACK  = 2'd3
    } bus_state_e;

    localparam logic [15:0] ERR_READ_VAL    = 16'hFFFF;
    localparam logic [15:0] IO_BASE_DEFAULT = 16'h4000;
    localparam int unsigned TIMEOUT_DEFAULT = 15;
    localparam int unsigned CNT_W_DEFAULT   = 4;

    // Word address [15:1] is widened back to a byte address for the decode.
    function automatic logic is_io_addr(input logic [15:1] adr, input logic [15:0] base);
        return ({adr, 1'b0} >= base);
    endfunction

endpackage

// File: rtl/j1a_bus_bridge_timer.sv
// Wait-state counter for the I/O path: clears when idle, counts while enabled,
// flags the terminal count.
module m_bus_timer
    import j1a_bus_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/j1a_bus_bridge.sv
// J1A downstream bus bridge: one shared ack for instruction/data accesses,
// RAM served from a dual-port sync RAM, upper space forwarded to Wishbone I/O.
module j1a_bus_bridge
    import j1a_bus_pkg::*;
#(
    parameter logic [15:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic        sys_clk_i,
    input  logic        sys_res_i,
    input  logic [13:1] cpu_ins_adr_i,
    output logic [15:0] cpu_ins_dat_o,
    input  logic [15:1] cpu_dat_adr_i,
    input  logic [15:0] cpu_dat_dat_i,
    output logic [15:0] cpu_dat_dat_o,
    input  logic        cpu_dat_we_i,
    input  logic        cpu_dat_cyc_i,
    input  logic        cpu_stb_i,
    output logic        cpu_ack_o,
    output logic [13:1] ram_ins_adr_o,
    input  logic [15:0] ram_ins_dat_i,
    output logic [13:1] ram_dat_adr_o,
    output logic [15:0] ram_dat_dat_o,
    input  logic [15:0] ram_dat_dat_i,
    output logic        ram_dat_we_o,
    output logic [15:1] io_adr_o,
    output logic [15:0] io_dat_o,
    input  logic [15:0] io_dat_i,
    output logic        io_we_o,
    output logic        io_cyc_o,
    output logic        io_stb_o,
    input  logic        io_ack_i,
    output logic        bus_err_o
);

    bus_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [15:1] adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] rdat_q, rdat_d;
    logic        err_q, err_d;
    logic        acc_io;
    logic        tmr_tc;

    assign acc_io = (cpu_dat_cyc_i | cpu_dat_we_i) & is_io_addr(cpu_dat_adr_i, IO_BASE);

    m_bus_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i (sys_clk_i),
        .rst_i (sys_res_i),
        .clr_i (state_q != ST_IO_WAIT),
        .en_i  (state_q == ST_IO_WAIT),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_stb_i) begin
                    we_d    = cpu_dat_we_i;
                    adr_d   = cpu_dat_adr_i;
                    wdat_d  = cpu_dat_dat_i;
                    state_d = acc_io ? ST_IO_WAIT : ST_RAM_ACK;
                end
            end
            ST_RAM_ACK: begin
                rdat_d  = ram_dat_dat_i;
                state_d = ST_IDLE;
            end
            ST_IO_WAIT: begin
                // A real ack on the terminal cycle takes priority over the timeout.
                if (io_ack_i) begin
                    rdat_d  = io_dat_i;
                    state_d = ST_IO_ACK;
                end else if (tmr_tc) begin
                    rdat_d  = ERR_READ_VAL;
                    err_d   = 1'b1;
                    state_d = ST_IO_ACK;
                end
            end
            ST_IO_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_res_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    assign cpu_ins_dat_o = ram_ins_dat_i;
    assign ram_ins_adr_o = cpu_ins_adr_i;
    // Live address feeds the 1-cycle RAM read; the latched one drives the store.
    assign ram_dat_adr_o = (state_q == ST_IDLE) ? cpu_dat_adr_i[13:1] : adr_q[13:1];
    assign ram_dat_dat_o = wdat_q;
    assign ram_dat_we_o  = (state_q == ST_RAM_ACK) & we_q;
    assign cpu_dat_dat_o = (state_q == ST_RAM_ACK) ? ram_dat_dat_i : rdat_q;
    assign cpu_ack_o     = ((state_q == ST_RAM_ACK) | (state_q == ST_IO_ACK)) & cpu_stb_i;
    assign io_adr_o      = adr_q;
    assign io_dat_o      = wdat_q;
    assign io_cyc_o      = (state_q == ST_IO_WAIT);
    assign io_stb_o      = io_cyc_o;
    assign io_we_o       = io_cyc_o & we_q;
    assign bus_err_o     = err_q;

endmodule
